// File: rtl/midi_uart_pkg.sv
// Shared definitions for the MIDI / UART serial receiver.
//   rx_state_t : receive FSM states
//   calc_div   : clocks per bit from core clock and line rate (truncated)
package midi_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Byte FIFO with show-ahead read port. Knows nothing about the serial side.
//   clk32, reset_n : clock, async active-low reset (empties the FIFO)
//   push, wdata    : write request; accepted when not full or when popping
//   pop            : take head; ignored while empty
//   rdata          : head entry (forced to 0 while empty)
//   full, empty    : status
//   count          : entries queued (0..DEPTH)
module rx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk32,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle;
  // the write lands in the slot being vacated.
  assign do_push = push && (!full || do_pop);

  // Gated so the head reads as zero whenever nothing is queued (incl. reset).
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk32) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth: pointers wrap by plain overflow.
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver (MIDI_IN / UART_RX) with output byte FIFO.
//   clk32     : core clock
//   reset_n   : async active-low reset, aborts any frame in progress
//   rxd       : raw serial pin, idle high
//   rx_data   : FIFO head byte (valid while rx_valid)
//   rx_valid  : FIFO non-empty
//   rx_pop    : consumer takes head this cycle
//   rx_count  : bytes queued
//   frame_err : 1-cycle pulse, stop bit sampled low
//   overrun   : 1-cycle pulse, byte dropped on a full FIFO
module midi_uart_rx
  import midi_uart_pkg::*;
#(
  parameter int CLK_HZ     = 32000000,
  parameter int BAUD       = 31250,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk32,
  input  logic                          reset_n,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_pop,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int DCW = $clog2(DIV);
  // dc counts down to zero; the expiry cycle is the sample cycle, so a
  // reload of N-1 places the next sample exactly N cycles later.
  localparam logic [DCW-1:0] HALF_LD = DCW'(DIV / 2 - 1);
  localparam logic [DCW-1:0] FULL_LD = DCW'(DIV - 1);

  if (DIV < 16) begin : g_bad_div
    $error("midi_uart_rx: CLK_HZ/BAUD must be at least 16");
  end

  // Pin synchronizer, preset to the idle level.
  logic [1:0] sync;
  logic       rxs;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], rxd};
  end
  assign rxs = sync[1];

  // Receive FSM
  rx_state_t      state, state_n;
  logic [DCW-1:0] dc, dc_n;
  logic [2:0]     bc, bc_n;
  logic [7:0]     sh, sh_n;
  logic           expired, push, ferr;
  logic           fifo_full, fifo_empty, pop_eff;

  assign expired = (dc == '0);

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dc    <= '0;
      bc    <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      dc    <= dc_n;
      bc    <= bc_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    dc_n    = expired ? dc : dc - 1'b1;
    bc_n    = bc;
    sh_n    = sh;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          dc_n    = HALF_LD;
        end
      end
      START: begin
        if (expired) begin
          if (rxs) begin
            state_n = IDLE;           // too short to be a start bit
          end else begin
            state_n = DATA;
            bc_n    = 3'd0;
            dc_n    = FULL_LD;
          end
        end
      end
      DATA: begin
        if (expired) begin
          sh_n = {rxs, sh[7:1]};      // LSB first: first bit ends in bit 0
          dc_n = FULL_LD;
          if (bc == 3'd7) state_n = STOP;
          else            bc_n    = bc + 3'd1;
        end
      end
      STOP: begin
        // IDLE is re-entered at the stop sample so a start edge half a
        // bit later is still caught.
        if (expired) begin
          if (rxs) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        // Held-low line: one frame_err, then wait for the line to recover.
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop_eff = rx_pop && !fifo_empty;

  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= push && fifo_full && !pop_eff;
    end
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk32   (clk32),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (sh),
    .pop     (rx_pop),
    .rdata   (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rx_count)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_midi_uart_rx.sv
module tb_midi_uart_rx;

  localparam int CLK_HZ     = 3200000;
  localparam int BAUD       = 100000;
  localparam int DIV        = CLK_HZ / BAUD;   // 32 clocks per bit
  localparam int FIFO_DEPTH = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk32 = 1'b0;
  logic          reset_n;
  logic          rxd;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_pop;
  logic [CW-1:0] rx_count;
  logic          frame_err;
  logic          overrun;

  midi_uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk32     (clk32),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_pop    (rx_pop),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk32 = ~clk32;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of bytes the receiver should hold, and expected
  // counts of pulse cycles for each error flag.
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         exp_ovr  = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  logic [7:0] b;
  int         per, gap;

  always @(negedge clk32) begin
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_push(input logic [7:0] v);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(v);
    else exp_ovr++;
  endfunction

  // Call at a negedge; drives one 8N1 frame with `p` clocks per bit.
  task automatic send_frame(input logic [7:0] v, input logic stop, input int p);
    rxd = 1'b0;
    repeat (p) @(negedge clk32);
    for (int i = 0; i < 8; i++) begin
      rxd = v[i];
      repeat (p) @(negedge clk32);
    end
    rxd = stop;
    repeat (p) @(negedge clk32);
    rxd = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, e);
    rx_pop = 1'b1;
    @(negedge clk32);
    rx_pop = 1'b0;
    check({tag, "_cnt"}, rx_count, exp_q.size());
  endtask

  initial begin
    reset_n = 1'b0;
    rxd     = 1'b1;
    rx_pop  = 1'b0;
    repeat (3) @(negedge clk32);
    check("rst_valid", rx_valid, 0);
    check("rst_count", rx_count, 0);
    check("rst_data",  rx_data, 0);
    check("rst_ferr",  frame_err, 0);
    check("rst_ovr",   overrun, 0);
    reset_n = 1'b1;
    repeat (DIV) @(negedge clk32);

    // Byte 0x90 with exact visibility timing: rxs falls 2 cycles after rxd,
    // stop sample DIV/2 + 9*DIV later, byte visible the cycle after.
    fork
      send_frame(8'h90, 1'b1, DIV);
      begin
        repeat (2 + DIV/2 + 9*DIV) @(negedge clk32);
        check("b90_early", rx_valid, 0);
        @(negedge clk32);
        check("b90_valid", rx_valid, 1);
        check("b90_count", rx_count, 1);
      end
    join
    model_push(8'h90);
    pop_check("b90");
    check("b90_empty", rx_valid, 0);

    // Glitch shorter than half a bit: ignored, receiver ready right after.
    rxd = 1'b0;
    repeat (10) @(negedge clk32);
    rxd = 1'b1;
    repeat (DIV/2 + 4) @(negedge clk32);
    check("glitch_cnt",  rx_count, 0);
    check("glitch_ferr", ferr_cnt, exp_ferr);
    send_frame(8'h5A, 1'b1, DIV);
    model_push(8'h5A);
    repeat (DIV) @(negedge clk32);
    pop_check("after_glitch");

    // Bad stop bit, line held low for 20 bit times: one frame_err, no byte.
    send_frame(8'h55, 1'b0, DIV);
    rxd = 1'b0;
    repeat (20*DIV) @(negedge clk32);
    rxd = 1'b1;
    exp_ferr++;
    repeat (DIV) @(negedge clk32);
    check("ferr_pulses", ferr_cnt, exp_ferr);
    check("ferr_cnt",    rx_count, 0);
    send_frame(8'h3C, 1'b1, DIV);
    model_push(8'h3C);
    repeat (DIV) @(negedge clk32);
    pop_check("after_ferr");

    // 17 back-to-back bytes, no pops: 16 kept, one overrun.
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1, DIV);
      model_push(8'(i));
    end
    repeat (DIV) @(negedge clk32);
    check("ovr_count",  rx_count, FIFO_DEPTH);
    check("ovr_pulses", ovr_cnt, exp_ovr);
    check("ovr_one",    exp_ovr, 1);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_check("ovr_drain");

    // Full FIFO with a pop in the push cycle of 0xA5.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, DIV);
      model_push(b);
    end
    repeat (DIV) @(negedge clk32);
    check("full_pre", rx_count, FIFO_DEPTH);
    fork
      send_frame(8'hA5, 1'b1, DIV);
      begin
        repeat (2 + DIV/2 + 9*DIV) @(negedge clk32);
        b = exp_q.pop_front();
        check("full_head", rx_data, b);
        rx_pop = 1'b1;
        @(negedge clk32);
        rx_pop = 1'b0;
        model_push(8'hA5);
        check("full_cnt", rx_count, FIFO_DEPTH);
        check("full_ovr", ovr_cnt, exp_ovr);
      end
    join
    check("full_last", exp_q[FIFO_DEPTH-1], 8'hA5);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_check("full_drain");

    // Random bytes, slight baud mismatch and random idle gaps.
    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom);
      per = DIV - 1 + int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, DIV));
      send_frame(b, 1'b1, per);
      model_push(b);
      repeat (gap) @(negedge clk32);
    end
    repeat (DIV) @(negedge clk32);
    check("rnd_count", rx_count, exp_q.size());
    while (exp_q.size() > 0) pop_check("rnd");
    check("rnd_ferr", ferr_cnt, exp_ferr);
    check("rnd_ovr",  ovr_cnt, exp_ovr);

    // Reset during data bit 4 with a byte already queued.
    send_frame(8'h11, 1'b1, DIV);
    model_push(8'h11);
    repeat (DIV) @(negedge clk32);
    check("prerst_cnt", rx_count, 1);
    fork
      send_frame(8'hC3, 1'b1, DIV);
      begin
        repeat (5*DIV + DIV/2) @(negedge clk32);
        reset_n = 1'b0;
        #1;
        check("mrst_valid", rx_valid, 0);
        check("mrst_count", rx_count, 0);
        check("mrst_data",  rx_data, 0);
        check("mrst_ferr",  frame_err, 0);
        check("mrst_ovr",   overrun, 0);
      end
    join
    exp_q.delete();
    reset_n = 1'b1;
    repeat (DIV) @(negedge clk32);
    send_frame(8'h7E, 1'b1, DIV);
    model_push(8'h7E);
    repeat (DIV) @(negedge clk32);
    check("post_rst_cnt", rx_count, 1);
    pop_check("post_rst");
    check("end_ferr", ferr_cnt, exp_ferr);
    check("end_ovr",  ovr_cnt, exp_ovr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/midi_uart_rx.md
# midi_uart_rx

Asynchronous serial receiver with an output FIFO for the MIDI_IN and UART_RX pins, the receive end of the core's MIDI_OUT/UART_TX links. The block oversamples the raw pin, reassembles 8N1 frames LSB-first and queues the bytes. The consumer, the MIDI/UART register logic inside c64_mist, drains them with a pop handshake. One instance is built per pin; the baud rate is set by parameter.

## Interface
- CLK_HZ, 32000000, clk32 frequency in Hz
- BAUD, 31250, line rate; DIV = CLK_HZ/BAUD (integer, truncated) clocks per bit; DIV ≥ 16 required (elaboration assertion)
- FIFO_DEPTH, 16, byte entries, power of two, ≥ 2
- clk32  input  1  core clock, all logic rising-edge
- reset_n  input  1  asynchronous, active-low reset
- rxd  input  1  raw serial pin, asynchronous, idle high
- rx_data  output  8  FIFO head byte, valid only while rx_valid=1
- rx_valid  output  1  FIFO non-empty
- rx_pop  input  1  consumer takes head this cycle; ignored when rx_valid=0
- rx_count  output  $clog2(FIFO_DEPTH)+1  bytes queued
- frame_err  output  1  one-cycle pulse, bad stop bit
- overrun  output  1  one-cycle pulse, byte dropped because the FIFO was full

## Operation
- rxd passes through a 2-FF synchronizer, preset to 1 on reset; rxs is the synchronized value. All decisions use rxs.
- The FSM has states IDLE, START, DATA, STOP, BREAK. A bit counter bc (0..7) and a divider counter dc (width $clog2(DIV)) run alongside it.
- IDLE: when rxs=0, go to START and load dc for DIV/2 cycles.
- START: at expiry, sample rxs. If rxs=1 it was a glitch; return to IDLE with no output. If rxs=0, go to DATA with bc=0 and a dc reload of DIV.
- DATA: at each expiry, shift rxs into the shift register MSB, so the first bit received ends up in bit 0. After bc=7, go to STOP with a reload of DIV.
- STOP: at expiry, sample rxs.
  - rxs=1: push the byte and go to IDLE.
  - rxs=0: pulse frame_err, discard the byte, go to BREAK.
- BREAK: stay until rxs=1, then go to IDLE. A held-low line produces exactly one frame_err.
- FIFO behaviour:
  - Show-ahead: rx_data equals the head entry combinationally from the registered read pointer.
  - A push is accepted if rx_count<FIFO_DEPTH, or if a pop happens in the same cycle. Otherwise the byte is dropped and overrun pulses.
  - Simultaneous push and pop leaves rx_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset, asserted at any time, aborts any frame in progress:
  - FSM returns to IDLE.
  - FIFO empties.
  - rx_valid=0, rx_count=0, frame_err=0, overrun=0, rx_data=0.
  - A frame partially received when reset is released is not recovered. If the line is low at release, the next falling edge is not guaranteed to be seen, but the FSM resynchronizes on the next idle-to-start transition.

## Timing
- Let T0 be the first cycle with rxs=0. rxd to rxs takes 2 cycles.
- Start sample at T0+DIV/2.
- Data bit k sample at T0+DIV/2+(k+1)·DIV.
- Stop sample at T0+DIV/2+9·DIV.
- Byte visible (rx_valid=1, rx_count incremented) in the cycle after the stop sample.
- frame_err and overrun assert in that same cycle, each for exactly 1 cycle.
- Pop: rx_count decrements and the next head appears in the cycle after rx_pop=1.
- Back-to-back frames are accepted: IDLE is re-entered at the stop sample, so a start edge arriving half a bit later is detected.
- Tolerated baud mismatch is ±3% at DIV=1024.

## Structure
- Package midi_uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK)
  - a function computing DIV from CLK_HZ and BAUD
- Sub-module rx_fifo contains the storage, the read/write pointers and the count. It provides the push/pop/full/empty handshake and has no knowledge of the serial side.
- The top of midi_uart_rx contains the synchronizer, the FSM and the counters, and instantiates rx_fifo.

## Test plan
- Byte 0x90 at BAUD=31250, CLK_HZ=32e6 (DIV=1024). The stop sample falls at T0+9728 and rx_valid rises at T0+9729 with rx_data=0x90. Then pop once: rx_valid=0 and rx_count=0 one cycle later.
- Glitch: rxd low for 300 cycles, then high. Required: no byte, no frame_err, FSM back in IDLE at T0+512.
- Frame error: byte 0x55 with the stop bit forced to 0 and the line held low for 20 bit times. Required: exactly one frame_err pulse, no push. Then send 0x3C: it is received correctly.
- Overrun: send 17 back-to-back bytes 0x00..0x10 with no pops. Required: rx_count=16 and one overrun pulse on the 17th byte. Pops then return 0x00..0x0F in order.
- Full plus simultaneous pop: with 16 bytes queued, assert rx_pop in the push cycle of byte 0xA5. Required: no overrun, rx_count stays 16, and 0xA5 is the last byte popped.
- Reset mid-frame: assert reset_n=0 during DATA bit 4 of a byte. Required: all outputs 0 immediately and the FIFO empty. After release plus one idle bit time, the next byte 0x7E is received correctly.
